// File: rtl/calc_sequencer.sv
// Main control FSM for the calculator: captures A, B and the op code on ENTER
// presses, launches the ALU and tracks its completion or timeout.
module calc_sequencer #(
    parameter int in_length = 16,
    parameter int op_width  = 2,
    parameter int TIMEOUT   = 255
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 ENTER,
    input  logic                 CLEAR,
    input  logic [in_length-1:0] DATA_IN,
    input  logic [op_width-1:0]  OP_IN,
    input  logic                 ALU_DONE,
    output logic [in_length-1:0] A_OUT,
    output logic [in_length-1:0] B_OUT,
    output logic [op_width-1:0]  OP_OUT,
    output logic                 ALU_START,
    output logic [1:0]           STATE,
    output logic                 BUSY,
    output logic                 ERROR
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_EMPTY,
        S_A,
        S_B,
        S_CALC,
        S_RES
    } state_t;

    state_t               state_q, state_d;
    logic [in_length-1:0] a_q, a_d;
    logic [in_length-1:0] b_q, b_d;
    logic [op_width-1:0]  op_q, op_d;
    logic                 start_q, start_d;
    logic [1:0]           code_q, code_d;
    logic                 busy_q, busy_d;
    logic                 err_q, err_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 enter_q;
    logic                 enterRise;

    assign enterRise = ENTER & ~enter_q;

    // Priority inside the calculation: CLEAR, then ALU_DONE, then timeout.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        start_d = 1'b0;
        err_d   = err_q;
        cnt_d   = cnt_q;
        if (CLEAR) begin
            state_d = S_EMPTY;
            a_d     = '0;
            b_d     = '0;
            op_d    = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_EMPTY: if (enterRise) begin
                    a_d     = DATA_IN;
                    err_d   = 1'b0;
                    state_d = S_A;
                end
                S_A: if (enterRise) begin
                    b_d     = DATA_IN;
                    state_d = S_B;
                end
                S_B: if (enterRise) begin
                    op_d    = OP_IN;
                    start_d = 1'b1;
                    cnt_d   = '0;
                    state_d = S_CALC;
                end
                S_CALC: begin
                    if (ALU_DONE) begin
                        state_d = S_RES;
                    end else if (cnt_q == CNT_LAST) begin
                        err_d   = 1'b1;
                        a_d     = '0;
                        b_d     = '0;
                        cnt_d   = '0;
                        state_d = S_EMPTY;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_RES: if (enterRise) begin
                    a_d     = '0;
                    b_d     = '0;
                    state_d = S_EMPTY;
                end
                default: state_d = S_EMPTY;
            endcase
        end

        case (state_d)
            S_A:     code_d = 2'd1;
            S_B:     code_d = 2'd2;
            S_CALC:  code_d = 2'd2;
            S_RES:   code_d = 2'd3;
            default: code_d = 2'd0;
        endcase
        busy_d = (state_d == S_CALC);
    end

    // Edge history resets high so a button held through reset is not an edge.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= S_EMPTY;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            start_q <= 1'b0;
            code_q  <= 2'd0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            enter_q <= 1'b1;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            start_q <= start_d;
            code_q  <= code_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            enter_q <= ENTER;
        end
    end

    assign A_OUT     = a_q;
    assign B_OUT     = b_q;
    assign OP_OUT    = op_q;
    assign ALU_START = start_q;
    assign STATE     = code_q;
    assign BUSY      = busy_q;
    assign ERROR     = err_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed scoreboard bench for calc_sequencer with TIMEOUT=8.
module tb_calc_sequencer;

    localparam int W  = 16;
    localparam int OW = 2;
    localparam int TO = 8;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          ENTER;
    logic          CLEAR;
    logic          ALU_DONE;
    logic [W-1:0]  DATA_IN;
    logic [OW-1:0] OP_IN;
    logic [W-1:0]  A_OUT;
    logic [W-1:0]  B_OUT;
    logic [OW-1:0] OP_OUT;
    logic          ALU_START;
    logic [1:0]    STATE;
    logic          BUSY;
    logic          ERROR;

    typedef struct {
        string         tag;
        logic [1:0]    st;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [OW-1:0] op;
        logic          start;
        logic          busy;
        logic          err;
    } expT;

    expT expQ[$];
    int  checks   = 0;
    int  failures = 0;

    calc_sequencer #(.in_length(W), .op_width(OW), .TIMEOUT(TO)) dut (
        .CLK(CLK), .RESET(RESET), .ENTER(ENTER), .CLEAR(CLEAR),
        .DATA_IN(DATA_IN), .OP_IN(OP_IN), .ALU_DONE(ALU_DONE),
        .A_OUT(A_OUT), .B_OUT(B_OUT), .OP_OUT(OP_OUT), .ALU_START(ALU_START),
        .STATE(STATE), .BUSY(BUSY), .ERROR(ERROR)
    );

    always #5 CLK = ~CLK;

    task automatic applyStimulus(input logic enter, input logic clear, input logic done,
                                 input logic [W-1:0] data, input logic [OW-1:0] op);
        ENTER    = enter;
        CLEAR    = clear;
        ALU_DONE = done;
        DATA_IN  = data;
        OP_IN    = op;
    endtask

    task automatic pushExpected(input string tag, input logic [1:0] st, input logic [W-1:0] a,
                                input logic [W-1:0] b, input logic [OW-1:0] op,
                                input logic start, input logic busy, input logic err);
        expT e;
        e.tag = tag; e.st = st; e.a = a; e.b = b; e.op = op;
        e.start = start; e.busy = busy; e.err = err;
        expQ.push_back(e);
    endtask

    task automatic checkOutput();
        expT e;
        logic [38:0] obs;
        logic [38:0] want;
        checks++;
        if (expQ.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_empty observed=none expected=entry");
            return;
        end
        e    = expQ.pop_front();
        obs  = {STATE, A_OUT, B_OUT, OP_OUT, ALU_START, BUSY, ERROR};
        want = {e.st, e.a, e.b, e.op, e.start, e.busy, e.err};
        assert (obs === want) else begin
            failures++;
            $error("FAIL %s observed st=%0d a=%h b=%h op=%0d start=%b busy=%b err=%b expected st=%0d a=%h b=%h op=%0d start=%b busy=%b err=%b",
                   e.tag, STATE, A_OUT, B_OUT, OP_OUT, ALU_START, BUSY, ERROR,
                   e.st, e.a, e.b, e.op, e.start, e.busy, e.err);
        end
    endtask

    // Drive inputs, record the outputs expected after the next edge, then check them.
    task automatic step(input string tag, input logic enter, input logic clear, input logic done,
                        input logic [W-1:0] data, input logic [OW-1:0] opIn,
                        input logic [1:0] st, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [OW-1:0] op, input logic start, input logic busy,
                        input logic err);
        applyStimulus(enter, clear, done, data, opIn);
        pushExpected(tag, st, a, b, op, start, busy, err);
        @(posedge CLK);
        #1;
        checkOutput();
    endtask

    initial begin
        RESET = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
        repeat (2) @(posedge CLK);
        #1;
        pushExpected("reset_state", 2'd0, 16'h0, 16'h0, 2'd0, 0, 0, 0);
        checkOutput();
        RESET = 1'b1;

        step("idle",       0, 0, 0, 16'h0000, 2'd0, 2'd0, 16'h0000, 16'h0000, 2'd0, 0, 0, 0);
        step("capture_a",  1, 0, 0, 16'h0012, 2'd0, 2'd1, 16'h0012, 16'h0000, 2'd0, 0, 0, 0);
        step("hold_a",     0, 0, 0, 16'h0012, 2'd0, 2'd1, 16'h0012, 16'h0000, 2'd0, 0, 0, 0);
        step("capture_b",  1, 0, 0, 16'h0034, 2'd0, 2'd2, 16'h0012, 16'h0034, 2'd0, 0, 0, 0);
        step("hold_b",     0, 0, 0, 16'h0034, 2'd0, 2'd2, 16'h0012, 16'h0034, 2'd0, 0, 0, 0);
        step("start",      1, 0, 0, 16'h0034, 2'd1, 2'd2, 16'h0012, 16'h0034, 2'd1, 1, 1, 0);
        step("busy1",      0, 0, 0, 16'h0034, 2'd1, 2'd2, 16'h0012, 16'h0034, 2'd1, 0, 1, 0);
        step("busy2",      0, 0, 0, 16'h0034, 2'd1, 2'd2, 16'h0012, 16'h0034, 2'd1, 0, 1, 0);
        step("done",       0, 0, 1, 16'h0034, 2'd1, 2'd3, 16'h0012, 16'h0034, 2'd1, 0, 0, 0);
        step("done_ignored", 0, 0, 1, 16'h0034, 2'd1, 2'd3, 16'h0012, 16'h0034, 2'd1, 0, 0, 0);
        step("res_hold",   0, 0, 0, 16'h0034, 2'd1, 2'd3, 16'h0012, 16'h0034, 2'd1, 0, 0, 0);
        step("res_exit",   1, 0, 0, 16'h0034, 2'd1, 2'd0, 16'h0000, 16'h0000, 2'd1, 0, 0, 0);
        step("empty_low",  0, 0, 0, 16'h0034, 2'd1, 2'd0, 16'h0000, 16'h0000, 2'd1, 0, 0, 0);

        for (int i = 0; i < 10; i++)
            step("held_button", 1, 0, 0, (i == 0) ? 16'h0077 : 16'h0099, 2'd1,
                 2'd1, 16'h0077, 16'h0000, 2'd1, 0, 0, 0);
        step("held_release", 0, 0, 0, 16'h0099, 2'd1, 2'd1, 16'h0077, 16'h0000, 2'd1, 0, 0, 0);

        step("clear_vs_enter", 1, 1, 0, 16'h00AB, 2'd1, 2'd0, 16'h0000, 16'h0000, 2'd0, 0, 0, 0);
        step("after_clear",    0, 0, 0, 16'h00AB, 2'd1, 2'd0, 16'h0000, 16'h0000, 2'd0, 0, 0, 0);

        step("to_a",   1, 0, 0, 16'h0001, 2'd0, 2'd1, 16'h0001, 16'h0000, 2'd0, 0, 0, 0);
        step("to_a_l", 0, 0, 0, 16'h0001, 2'd0, 2'd1, 16'h0001, 16'h0000, 2'd0, 0, 0, 0);
        step("to_b",   1, 0, 0, 16'h0002, 2'd0, 2'd2, 16'h0001, 16'h0002, 2'd0, 0, 0, 0);
        step("to_b_l", 0, 0, 0, 16'h0002, 2'd0, 2'd2, 16'h0001, 16'h0002, 2'd0, 0, 0, 0);
        step("to_calc", 1, 0, 0, 16'h0002, 2'd3, 2'd2, 16'h0001, 16'h0002, 2'd3, 1, 1, 0);
        for (int i = 1; i < TO; i++)
            step("wait_busy", (i == 2), 0, 0, 16'h0002, 2'd3, 2'd2, 16'h0001, 16'h0002, 2'd3, 0, 1, 0);
        step("timeout",  0, 0, 0, 16'h0002, 2'd3, 2'd0, 16'h0000, 16'h0000, 2'd3, 0, 0, 1);
        step("err_sticky", 0, 0, 0, 16'h0005, 2'd3, 2'd0, 16'h0000, 16'h0000, 2'd3, 0, 0, 1);
        step("err_clear", 1, 0, 0, 16'h0005, 2'd3, 2'd1, 16'h0005, 16'h0000, 2'd3, 0, 0, 0);
        step("err_clear_l", 0, 0, 0, 16'h0005, 2'd3, 2'd1, 16'h0005, 16'h0000, 2'd3, 0, 0, 0);

        step("race_b",   1, 0, 0, 16'h0006, 2'd0, 2'd2, 16'h0005, 16'h0006, 2'd3, 0, 0, 0);
        step("race_b_l", 0, 0, 0, 16'h0006, 2'd0, 2'd2, 16'h0005, 16'h0006, 2'd3, 0, 0, 0);
        step("race_start", 1, 0, 0, 16'h0006, 2'd2, 2'd2, 16'h0005, 16'h0006, 2'd2, 1, 1, 0);
        for (int i = 1; i < TO; i++)
            step("race_busy", 0, 0, 0, 16'h0006, 2'd2, 2'd2, 16'h0005, 16'h0006, 2'd2, 0, 1, 0);
        step("race_done", 0, 0, 1, 16'h0006, 2'd2, 2'd3, 16'h0005, 16'h0006, 2'd2, 0, 0, 0);
        step("race_exit", 1, 0, 0, 16'h0006, 2'd2, 2'd0, 16'h0000, 16'h0000, 2'd2, 0, 0, 0);
        step("race_exit_l", 0, 0, 0, 16'h0006, 2'd2, 2'd0, 16'h0000, 16'h0000, 2'd2, 0, 0, 0);

        step("cd_a",   1, 0, 0, 16'h0011, 2'd1, 2'd1, 16'h0011, 16'h0000, 2'd2, 0, 0, 0);
        step("cd_a_l", 0, 0, 0, 16'h0011, 2'd1, 2'd1, 16'h0011, 16'h0000, 2'd2, 0, 0, 0);
        step("cd_b",   1, 0, 0, 16'h0022, 2'd1, 2'd2, 16'h0011, 16'h0022, 2'd2, 0, 0, 0);
        step("cd_b_l", 0, 0, 0, 16'h0022, 2'd1, 2'd2, 16'h0011, 16'h0022, 2'd2, 0, 0, 0);
        step("cd_start", 1, 0, 0, 16'h0022, 2'd1, 2'd2, 16'h0011, 16'h0022, 2'd1, 1, 1, 0);
        step("clear_vs_done", 0, 1, 1, 16'h0022, 2'd1, 2'd0, 16'h0000, 16'h0000, 2'd0, 0, 0, 0);

        step("ar_a",   1, 0, 0, 16'h0033, 2'd3, 2'd1, 16'h0033, 16'h0000, 2'd0, 0, 0, 0);
        step("ar_a_l", 0, 0, 0, 16'h0033, 2'd3, 2'd1, 16'h0033, 16'h0000, 2'd0, 0, 0, 0);
        step("ar_b",   1, 0, 0, 16'h0044, 2'd3, 2'd2, 16'h0033, 16'h0044, 2'd0, 0, 0, 0);
        step("ar_b_l", 0, 0, 0, 16'h0044, 2'd3, 2'd2, 16'h0033, 16'h0044, 2'd0, 0, 0, 0);
        step("ar_start", 1, 0, 0, 16'h0044, 2'd3, 2'd2, 16'h0033, 16'h0044, 2'd3, 1, 1, 0);
        #3;
        RESET = 1'b0;
        #1;
        pushExpected("async_reset", 2'd0, 16'h0, 16'h0, 2'd0, 0, 0, 0);
        checkOutput();

        ENTER = 1'b1;
        @(posedge CLK);
        #4;
        RESET = 1'b1;
        for (int i = 0; i < 3; i++)
            step("enter_thru_reset", 1, 0, 0, 16'h0055, 2'd0, 2'd0, 16'h0000, 16'h0000, 2'd0, 0, 0, 0);
        step("post_reset_low", 0, 0, 0, 16'h0055, 2'd0, 2'd0, 16'h0000, 16'h0000, 2'd0, 0, 0, 0);
        step("post_reset_a",   1, 0, 0, 16'h0055, 2'd0, 2'd1, 16'h0055, 16'h0000, 2'd0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
- Main control FSM for the calculator datapath.
- Captures operand A, operand B and the operation code from switches on successive ENTER presses.
- Starts the ALU and waits for its completion handshake.
- Drives the 2-bit STATE code used by the display register: 0 = empty, 1 = A, 2 = B, 3 = result.

Parameters:
- in_length, 16, operand width in bits.
- op_width, 2, operation code width in bits.
- TIMEOUT, 255, maximum cycles to wait for ALU_DONE before aborting; must be >= 2.

Ports:
- CLK  input  1  system clock, rising edge.
- RESET  input  1  asynchronous, active-low reset.
- ENTER  input  1  debounced, synchronized button level; acts on its rising edge.
- CLEAR  input  1  synchronous abort/clear, level, active-high.
- DATA_IN  input  in_length  operand value from switches.
- OP_IN  input  op_width  operation select from switches.
- ALU_DONE  input  1  ALU completion pulse; the result is valid on RESULTADO.
- A_OUT  output  in_length  registered operand A.
- B_OUT  output  in_length  registered operand B.
- OP_OUT  output  op_width  registered operation code.
- ALU_START  output  1  single-cycle start pulse to the ALU.
- STATE  output  2  display selection code.
- BUSY  output  1  high while waiting for the ALU.
- ERROR  output  1  sticky ALU-timeout flag.

Behaviour:
- Reset (RESET=0, asynchronous) sets:
  - FSM to S_EMPTY; A_OUT=0, B_OUT=0, OP_OUT=0.
  - ALU_START=0, STATE=0, BUSY=0, ERROR=0.
  - Timeout counter=0; ENTER history register=1.
  - Because the history register resets to 1, an ENTER held through reset release produces no rising edge.
- Edge detect: enter_rise = ENTER & ~enter_q, where enter_q is ENTER registered each cycle.
- All outputs are registered. An event sampled at clock edge n is visible after edge n, with no combinational paths from input to output.
- FSM states and the STATE output in each:
  - S_EMPTY (STATE=0): on enter_rise, A_OUT<=DATA_IN and go to S_A.
  - S_A (STATE=1): on enter_rise, B_OUT<=DATA_IN and go to S_B.
  - S_B (STATE=2): on enter_rise, OP_OUT<=OP_IN, ALU_START<=1 for exactly one cycle, counter<=0, and go to S_CALC.
  - S_CALC (STATE=2, BUSY=1):
    - On ALU_DONE, go to S_RES.
    - Otherwise the counter increments each cycle.
    - When the counter equals TIMEOUT-1 with no ALU_DONE, set ERROR<=1 and go to S_EMPTY. A_OUT and B_OUT are cleared to 0.
  - S_RES (STATE=3): on enter_rise, go to S_EMPTY and clear A_OUT and B_OUT to 0.
- ERROR is sticky. It clears only on reset, or on the first enter_rise accepted in S_EMPTY; that same edge still captures A.
- CLEAR=1 in any state:
  - Next state is S_EMPTY; A_OUT, B_OUT and OP_OUT go to 0; ALU_START=0; counter=0.
  - ERROR is unchanged.
- Priority: CLEAR > ALU_DONE > timeout > enter_rise.
- ALU_DONE in the same cycle as the timeout condition counts as success: go to S_RES with no ERROR.
- ALU_DONE outside S_CALC is ignored.
- enter_rise in S_CALC is ignored and not queued.
- ENTER held high across multiple cycles gives exactly one advance.
- ALU_START is never asserted in two consecutive cycles.
- STATE encoding is fixed:
  - 0 means no data; 1 shows A; 2 shows B, including during the calculation; 3 shows the result.

Test Plan:
- Normal operation:
  - Stimulus: release reset, then ENTER pulses with DATA_IN=16'h0012, DATA_IN=16'h0034, OP_IN=2'd1, then ALU_DONE 3 cycles after ALU_START.
  - Required: STATE sequence 0→1→2→2→3; A_OUT=0012, B_OUT=0034, OP_OUT=1; exactly one ALU_START pulse; BUSY high for 3 cycles.
- Held button:
  - ENTER held high for 10 cycles in S_EMPTY → single advance to STATE=1.
  - ENTER held high through reset release → STATE stays 0.
- Timeout with TIMEOUT=8:
  - No ALU_DONE → after 8 cycles in S_CALC: ERROR=1, STATE=0, A_OUT=B_OUT=0.
  - Next ENTER with DATA_IN=5 → ERROR=0, STATE=1, A_OUT=5.
- Done versus timeout race: ALU_DONE on exactly the cycle the counter reaches TIMEOUT-1 → STATE=3 and ERROR=0.
- CLEAR priority:
  - CLEAR asserted together with ALU_DONE in S_CALC → STATE=0 and all operand registers 0.
  - CLEAR asserted together with enter_rise in S_A → B_OUT remains 0.
- Asynchronous reset in S_CALC, mid-clock-period → all outputs 0 immediately, before the next edge; ALU_START=0.
